jam_search: RTL and testbench

- Parametrised exhaustive job-assignment search engine for N workers and N jobs, N from 2 to 8.
- Enumerates all N! assignments in lexicographic order and fetches each cost from an external combinational cost ROM over the W/J/Cost interface.
- Reports the optimal total cost, the number of assignments reaching it, and the first optimal assignment found.
- Supports minimum or maximum search mode and a start/busy/valid handshake, so the block can be rerun without reset.

---
 rtl/jam_pkg.sv | 26 ++
 rtl/jam_next_perm.sv | 63 ++++++
 rtl/jam_search.sv | 184 ++++++++++++++++++
 tb/tb_jam_search.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment search engine.
// Permutations are stored at the maximum supported size; only the first N entries matter.
package jam_pkg;

   localparam int IDX_W = 3;
   localparam int MAX_N = 8;

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

   typedef logic [IDX_W-1:0] idx_t;
   typedef idx_t [MAX_N-1:0] perm_t;

   function automatic perm_t identity_perm();
      perm_t p;
      for (int i = 0; i < MAX_N; i++) p[i] = idx_t'(i);
      return p;
   endfunction

   function automatic int unsigned factorial(input int unsigned n);
      int unsigned f;
      f = 1;
      for (int unsigned i = 2; i <= n; i++) f = f * i;
      return f;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational next-lexicographic-permutation step over the first N entries.
// 'last' flags a fully descending permutation (no pivot exists).
module jam_next_perm
   import jam_pkg::*;
#(
   parameter int N = 8
) (
   input  perm_t perm,
   output perm_t next_perm,
   output logic  last
);

   logic  found;
   int    piv;
   int    sj;
   idx_t  piv_val;
   idx_t  sj_val;
   perm_t swapped;

   always_comb begin
      found = 1'b0;
      piv   = 0;
      for (int i = 0; i < N-1; i++) begin
         if (perm[i] < perm[i+1]) begin
            found = 1'b1;
            piv   = i;
         end
      end

      piv_val = '0;
      for (int i = 0; i < N; i++) begin
         if (i == piv) piv_val = perm[i];
      end

      // Rightmost successor of the pivot; the suffix is descending so this is the smallest larger value.
      sj     = piv;
      sj_val = piv_val;
      for (int i = 0; i < N; i++) begin
         if (i > piv && perm[i] > piv_val) begin
            sj     = i;
            sj_val = perm[i];
         end
      end

      swapped = perm;
      for (int i = 0; i < N; i++) begin
         if (i == piv)     swapped[i] = sj_val;
         else if (i == sj) swapped[i] = piv_val;
      end

      next_perm = swapped;
      for (int i = 0; i < N; i++) begin
         if (i > piv) begin
            for (int q = 0; q < N; q++) begin
               if (q == N + piv - i) next_perm[i] = swapped[q];
            end
         end
      end

      last = ~found;
   end

endmodule

// File: rtl/jam_search.sv
// Exhaustive N x N assignment search: walks all N! permutations in lexicographic order,
// summing ROM costs per assignment and tracking the best sum, its multiplicity and first witness.
module jam_search
   import jam_pkg::*;
#(
   parameter int N      = 8,
   parameter int COST_W = 7,
   parameter int ACC_W  = COST_W + 3,
   parameter int CNT_W  = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               Start,
   input  logic               Mode,
   output logic [IDX_W-1:0]   W,
   output logic [IDX_W-1:0]   J,
   input  logic [COST_W-1:0]  Cost,
   output logic               Busy,
   output logic               Valid,
   output logic [CNT_W-1:0]   MatchCount,
   output logic [ACC_W-1:0]   MinCost,
   output logic [3*N-1:0]     BestPerm
);

   if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("jam_search: N must be in 2..8");
   end

   localparam idx_t K_LAST = idx_t'(N-1);

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   perm_t              perm_q, perm_d;
   idx_t               k_q, k_d;
   idx_t               w_q, w_d;
   idx_t               j_q, j_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               first_q, first_d;
   logic [ACC_W-1:0]   best_q, best_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [3*N-1:0]     best_perm_q, best_perm_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic [ACC_W-1:0]   min_cost_q, min_cost_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
   logic [3*N-1:0]     best_perm_out_q, best_perm_out_d;

   perm_t              nxt_perm;
   logic               perm_last;
   logic               better;
   idx_t               k_inc;

   jam_next_perm #(.N(N)) u_next_perm (
      .perm      (perm_q),
      .next_perm (nxt_perm),
      .last      (perm_last)
   );

   assign k_inc  = k_q + idx_t'(1);
   assign better = mode_q ? (acc_q > best_q) : (acc_q < best_q);

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      perm_d          = perm_q;
      k_d             = k_q;
      w_d             = w_q;
      j_d             = j_q;
      acc_d           = acc_q;
      first_d         = first_q;
      best_d          = best_q;
      count_d         = count_q;
      best_perm_d     = best_perm_q;
      busy_d          = busy_q;
      valid_d         = valid_q;
      min_cost_d      = min_cost_q;
      match_cnt_d     = match_cnt_q;
      best_perm_out_d = best_perm_out_q;

      case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               mode_d  = Mode;
               perm_d  = identity_perm();
               acc_d   = '0;
               k_d     = '0;
               w_d     = '0;
               j_d     = '0;
               first_d = 1'b1;
               valid_d = 1'b0;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end

         FETCH: begin
            acc_d = acc_q + ACC_W'(Cost);
            if (k_q == K_LAST) begin
               state_d = UPDATE;
            end else begin
               k_d = k_inc;
               w_d = k_inc;
               j_d = perm_q[k_inc];
            end
         end

         UPDATE: begin
            if (first_q || better) begin
               best_d      = acc_q;
               count_d     = CNT_W'(1);
               best_perm_d = perm_q[N-1:0];
            end else if (acc_q == best_q) begin
               count_d = count_q + CNT_W'(1);
            end
            first_d = 1'b0;
            acc_d   = '0;
            k_d     = '0;
            if (perm_last) begin
               // Publish the final tally, including this last permutation's contribution.
               state_d         = DONE;
               busy_d          = 1'b0;
               valid_d         = 1'b1;
               min_cost_d      = best_d;
               match_cnt_d     = count_d;
               best_perm_out_d = best_perm_d;
            end else begin
               state_d = FETCH;
               perm_d  = nxt_perm;
               w_d     = '0;
               j_d     = nxt_perm[0];
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q         <= IDLE;
         mode_q          <= 1'b0;
         perm_q          <= identity_perm();
         k_q             <= '0;
         w_q             <= '0;
         j_q             <= '0;
         acc_q           <= '0;
         first_q         <= 1'b0;
         best_q          <= '0;
         count_q         <= '0;
         best_perm_q     <= '0;
         busy_q          <= 1'b0;
         valid_q         <= 1'b0;
         min_cost_q      <= '0;
         match_cnt_q     <= '0;
         best_perm_out_q <= '0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         perm_q          <= perm_d;
         k_q             <= k_d;
         w_q             <= w_d;
         j_q             <= j_d;
         acc_q           <= acc_d;
         first_q         <= first_d;
         best_q          <= best_d;
         count_q         <= count_d;
         best_perm_q     <= best_perm_d;
         busy_q          <= busy_d;
         valid_q         <= valid_d;
         min_cost_q      <= min_cost_d;
         match_cnt_q     <= match_cnt_d;
         best_perm_out_q <= best_perm_out_d;
      end
   end

   assign W          = w_q;
   assign J          = j_q;
   assign Busy       = busy_q;
   assign Valid      = valid_q;
   assign MinCost    = min_cost_q;
   assign MatchCount = match_cnt_q;
   assign BestPerm   = best_perm_out_q;

endmodule

// File: tb/tb_jam_search.sv
// Randomised bench for jam_search (N=4): a brute-force assignment model plus a
// cycle-level handshake model are compared against the DUT every cycle.
module tb_jam_search;
   import jam_pkg::*;

   localparam int N      = 4;
   localparam int COST_W = 7;
   localparam int ACC_W  = COST_W + 3;
   localparam int CNT_W  = 16;
   localparam int PW     = 3*N;

   logic              CLK;
   logic              RST;
   logic              Start;
   logic              Mode;
   logic [2:0]        W;
   logic [2:0]        J;
   logic [COST_W-1:0] Cost;
   logic              Busy;
   logic              Valid;
   logic [CNT_W-1:0]  MatchCount;
   logic [ACC_W-1:0]  MinCost;
   logic [PW-1:0]     BestPerm;

   logic [COST_W-1:0] rom [8][8];
   assign Cost = rom[W][J];

   jam_search #(.N(N), .COST_W(COST_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Start      (Start),
      .Mode       (Mode),
      .W          (W),
      .J          (J),
      .Cost       (Cost),
      .Busy       (Busy),
      .Valid      (Valid),
      .MatchCount (MatchCount),
      .MinCost    (MinCost),
      .BestPerm   (BestPerm)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_chk  = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   typedef struct packed {
      logic [ACC_W-1:0] best;
      logic [CNT_W-1:0] cnt;
      logic [PW-1:0]    perm;
   } res_t;

   function automatic logic [PW-1:0] pk4(input int a, input int b, input int c, input int d);
      logic [PW-1:0] p;
      p = '0;
      p[2:0]   = 3'(a);
      p[5:3]   = 3'(b);
      p[8:6]   = 3'(c);
      p[11:9]  = 3'(d);
      return p;
   endfunction

   // Brute force: count through all N^N digit strings in increasing order (lexicographic),
   // keep those with distinct digits.
   function automatic res_t model_search(input logic mx);
      res_t r;
      int   d [N];
      int   t, sum, total;
      bit   ok, first;
      r = '0;
      first = 1'b1;
      total = 1;
      for (int i = 0; i < N; i++) total = total * N;
      for (int x = 0; x < total; x++) begin
         t = x;
         for (int w = N-1; w >= 0; w--) begin
            d[w] = t % N;
            t    = t / N;
         end
         ok = 1'b1;
         for (int a = 0; a < N; a++)
            for (int b = a+1; b < N; b++)
               if (d[a] == d[b]) ok = 1'b0;
         if (ok) begin
            sum = 0;
            for (int w = 0; w < N; w++) sum = sum + int'(rom[w][d[w]]);
            if (first || (mx ? (sum > int'(r.best)) : (sum < int'(r.best)))) begin
               first  = 1'b0;
               r.best = ACC_W'(sum);
               r.cnt  = CNT_W'(1);
               for (int w = 0; w < N; w++) r.perm[3*w +: 3] = 3'(d[w]);
            end else if (sum == int'(r.best)) begin
               r.cnt = r.cnt + CNT_W'(1);
            end
         end
      end
      return r;
   endfunction

   // Handshake/timing model: results appear N!*(N+1) edges after the accepted Start.
   logic m_busy, m_valid;
   int   m_rem;
   res_t m_res, pend;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_rem   <= 0;
         m_res   <= '0;
         pend    <= '0;
      end else if (m_busy) begin
         if (m_rem == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
            m_res   <= pend;
         end else begin
            m_rem <= m_rem - 1;
         end
      end else if (Start) begin
         m_busy  <= 1'b1;
         m_valid <= 1'b0;
         m_rem   <= int'(factorial(N)) * (N+1);
         pend    <= model_search(Mode);
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("busy",       64'(Busy),       64'(m_busy));
         chk("valid",      64'(Valid),      64'(m_valid));
         chk("mincost",    64'(MinCost),    64'(m_res.best));
         chk("matchcount", 64'(MatchCount), 64'(m_res.cnt));
         chk("bestperm",   64'(BestPerm),   64'(m_res.perm));
      end
   end

   task automatic set_rom_const(input int v);
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom[w][j] = COST_W'(v);
   endtask

   task automatic set_rom_diag();
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom[w][j] = (w == j) ? 7'd0 : 7'd10;
   endtask

   task automatic set_rom_absdiff();
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom[w][j] = COST_W'((w > j) ? w - j : j - w);
   endtask

   task automatic set_rom_rand(input int maxv);
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom[w][j] = COST_W'($urandom_range(maxv));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_w"},     64'(W),          64'd0);
      chk({tag, "_j"},     64'(J),          64'd0);
      chk({tag, "_busy"},  64'(Busy),       64'd0);
      chk({tag, "_valid"}, 64'(Valid),      64'd0);
      chk({tag, "_min"},   64'(MinCost),    64'd0);
      chk({tag, "_cnt"},   64'(MatchCount), 64'd0);
      chk({tag, "_perm"},  64'(BestPerm),   64'd0);
   endtask

   // act: 0 plain run, 1 extra Start pulse mid-search, 2 reset mid-search (abandons the run)
   task automatic run(input logic md, input int act);
      logic [ACC_W-1:0] old_min;
      logic [CNT_W-1:0] old_cnt;
      int lat;
      old_min = MinCost;
      old_cnt = MatchCount;
      @(negedge CLK);
      Start = 1'b1;
      Mode  = md;
      @(posedge CLK);
      #1 Start = 1'b0;
      chk("valid_drop", 64'(Valid), 64'd0);
      chk("busy_rise",  64'(Busy),  64'd1);
      chk("min_held",   64'(MinCost), 64'(old_min));
      chk("cnt_held",   64'(MatchCount), 64'(old_cnt));
      lat = 0;
      while (!Valid && lat < 2000) begin
         @(posedge CLK);
         #1 lat++;
         if (act == 1 && lat == 30) begin
            Start = 1'b1;
            Mode  = ~md;
            @(posedge CLK);
            #1 Start = 1'b0;
            lat++;
            chk("ignored_start_busy", 64'(Busy), 64'd1);
         end
         if (act == 2 && lat == 40) begin
            RST = 1'b1;
            #1 check_all_zero("midrst");
            @(negedge CLK);
            RST = 1'b0;
            return;
         end
      end
      chk("latency", 64'(lat), 64'(int'(factorial(N)) * (N+1)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      res_t r;
      RST   = 1'b1;
      Start = 1'b0;
      Mode  = 1'b0;
      set_rom_const(0);

      // Pin the reference model with hand-derived answers.
      set_rom_absdiff();
      r = model_search(1'b1);
      chk("pin_abs_best", 64'(r.best), 64'd8);
      chk("pin_abs_cnt",  64'(r.cnt),  64'd4);
      chk("pin_abs_perm", 64'(r.perm), 64'(pk4(2, 3, 0, 1)));
      set_rom_diag();
      r = model_search(1'b1);
      chk("pin_der_best", 64'(r.best), 64'd40);
      chk("pin_der_cnt",  64'(r.cnt),  64'd9);
      chk("pin_der_perm", 64'(r.perm), 64'(pk4(1, 0, 3, 2)));

      repeat (3) @(negedge CLK);
      check_all_zero("reset");
      RST = 1'b0;
      chk_en = 1'b1;

      set_rom_const(5);
      run(1'b0, 0);
      chk("const_min",  64'(MinCost),    64'd20);
      chk("const_cnt",  64'(MatchCount), 64'd24);
      chk("const_perm", 64'(BestPerm),   64'(pk4(0, 1, 2, 3)));

      set_rom_diag();
      run(1'b0, 0);
      chk("diag_min",  64'(MinCost),    64'd0);
      chk("diag_cnt",  64'(MatchCount), 64'd1);
      chk("diag_perm", 64'(BestPerm),   64'(pk4(0, 1, 2, 3)));
      run(1'b1, 0);
      chk("der_min",  64'(MinCost),    64'd40);
      chk("der_cnt",  64'(MatchCount), 64'd9);
      chk("der_perm", 64'(BestPerm),   64'(pk4(1, 0, 3, 2)));

      set_rom_absdiff();
      run(1'b1, 0);
      chk("abs_min",  64'(MinCost),    64'd8);
      chk("abs_cnt",  64'(MatchCount), 64'd4);
      chk("abs_perm", 64'(BestPerm),   64'(pk4(2, 3, 0, 1)));

      for (int it = 0; it < 8; it++) begin
         set_rom_rand((it % 2 == 0) ? 3 : 127);
         if (it == 2)      run(1'($urandom_range(1)), 1);
         else if (it == 5) run(1'($urandom_range(1)), 2);
         else              run(1'($urandom_range(1)), 0);
      end

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
